// File: rtl/cic_interp_pkg.sv
// Shared constants, state type and helpers for the two-stage CIC interpolator.
package cic_interp_pkg;

    localparam int unsigned CIC_DLY_DEPTH = 256;
    localparam int unsigned CIC_DLY_AW    = 8;
    localparam int unsigned CIC_ACC_W     = 64;
    localparam int unsigned CIC_COMB_W    = 49;
    localparam int unsigned CIC_TC_MAX    = 7;

    typedef enum logic {
        CLEAR,
        RUN
    } cic_state_t;

    function automatic logic [2:0] clamp_tc(input logic [3:0] tc);
        return (tc > 4'(CIC_TC_MAX)) ? 3'(CIC_TC_MAX) : tc[2:0];
    endfunction

endpackage

// File: rtl/cic_delay_line.sv
// Simple dual-port RAM used as a comb delay line; registered read, no reset on the array.
module cic_delay_line
    import cic_interp_pkg::*;
#(
    parameter int unsigned W     = CIC_COMB_W,
    parameter int unsigned DEPTH = CIC_DLY_DEPTH,
    parameter int unsigned AW    = CIC_DLY_AW
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/cic_interp.sv
// Two-stage CIC interpolator: low-rate combs on RAM delay lines, zero-stuffing,
// high-rate integrators and a run-time selectable differential delay M = 2^TC.
module cic_interp
    import cic_interp_pkg::*;
#(
    parameter int unsigned RATE     = 2,
    parameter int unsigned LOG2RATE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hi_tick,
    input  logic [3:0]  TC,
    input  logic [31:0] IN,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] OUT,
    output logic        out_tick,
    output logic        busy,
    output logic        underrun,
    input  logic        underrun_clr
);

    localparam int unsigned PH_W = (LOG2RATE > 0) ? LOG2RATE : 1;
    localparam int unsigned CW   = CIC_COMB_W;
    localparam int unsigned AW   = CIC_DLY_AW;
    localparam int unsigned ACCW = CIC_ACC_W;

    cic_state_t r_state, w_state_next;

    logic [AW-1:0]   r_clr_addr;
    logic [2:0]      r_tc;
    logic [AW-1:0]   r_ptr;
    logic [1:0]      r_stg;
    logic [CW-1:0]   r_x, r_c1, r_c2;
    logic            r_pending;
    logic [PH_W-1:0] r_phase;
    logic [ACCW-1:0] r_int1, r_int2;
    logic [31:0]     r_out;
    logic            r_out_tick;
    logic            r_underrun;

    logic [2:0]        w_tc_clamp;
    logic              w_tc_change;
    logic              w_accept;
    logic              w_tick;
    logic              w_take;
    logic              w_new_ur;
    logic [ACCW-1:0]   w_inj, w_int1_n, w_int2_n;
    logic [5:0]        w_shift;
    logic signed [ACCW-1:0] w_shifted;
    logic [31:0]       w_out_sat;
    logic [PH_W-1:0]   w_phase_next;
    logic [AW-1:0]     w_m, w_raddr;
    logic [CW-1:0]     w_d1, w_d2, w_c1, w_c2;
    logic              w_we1, w_we2;
    logic [AW-1:0]     w_waddr;
    logic [CW-1:0]     w_wdata1, w_wdata2;

    assign busy     = (r_state == CLEAR);
    assign in_ready = (r_state == RUN) && !r_pending && (r_stg == 2'd0) && !w_tc_change;
    assign OUT      = r_out;
    assign out_tick = r_out_tick;
    assign underrun = r_underrun;

    always_comb begin
        w_tc_clamp  = clamp_tc(TC);
        w_tc_change = (r_state == RUN) && (w_tc_clamp != r_tc);
        w_accept    = in_valid && in_ready;
        w_tick      = (r_state == RUN) && hi_tick && !w_tc_change;
        // A phase-0 tick during the comb pipeline sees no pending sample.
        w_take      = w_tick && (r_phase == '0) && r_pending;
        w_new_ur    = w_tick && (r_phase == '0) && !r_pending;
        w_inj       = w_take ? {{(ACCW - CW){r_c2[CW-1]}}, r_c2} : '0;
        w_int1_n    = r_int1 + w_inj;
        w_int2_n    = r_int2 + w_int1_n;
        w_shift     = {2'b00, r_tc, 1'b0} + 6'(LOG2RATE);
        w_shifted   = $signed(w_int2_n) >>> w_shift;
        if (w_shifted[ACCW-1:31] == {(ACCW - 31){w_shifted[31]}}) begin
            w_out_sat = w_shifted[31:0];
        end else begin
            w_out_sat = w_shifted[ACCW-1] ? 32'h8000_0000 : 32'h7fff_ffff;
        end
        w_phase_next = (r_phase == PH_W'(RATE - 1)) ? '0 : r_phase + 1'b1;
    end

    always_comb begin
        w_m      = AW'(1) << r_tc;
        w_raddr  = r_ptr - w_m;
        w_c1     = r_x - w_d1;
        w_c2     = r_c1 - w_d2;
        w_we1    = busy || (r_stg == 2'd1);
        w_we2    = busy || (r_stg == 2'd2);
        w_waddr  = busy ? r_clr_addr : r_ptr;
        w_wdata1 = busy ? '0 : r_x;
        w_wdata2 = busy ? '0 : r_c1;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CLEAR: if (r_clr_addr == AW'(CIC_DLY_DEPTH - 1)) w_state_next = RUN;
            RUN:   if (w_tc_change) w_state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= CLEAR;
            r_clr_addr <= '0;
            r_tc       <= '0;
            r_ptr      <= '0;
            r_stg      <= '0;
            r_x        <= '0;
            r_c1       <= '0;
            r_c2       <= '0;
            r_pending  <= 1'b0;
            r_phase    <= '0;
            r_int1     <= '0;
            r_int2     <= '0;
            r_out      <= '0;
            r_out_tick <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_out_tick <= w_tick;
            r_underrun <= (r_underrun && !underrun_clr) || w_new_ur;
            if (r_state == CLEAR) begin
                r_clr_addr <= r_clr_addr + 1'b1;
            end else if (w_tc_change) begin
                r_tc       <= w_tc_clamp;
                r_int1     <= '0;
                r_int2     <= '0;
                r_pending  <= 1'b0;
                r_stg      <= '0;
                r_ptr      <= '0;
                r_clr_addr <= '0;
            end else begin
                if (w_accept) begin
                    r_x   <= {{(CW - 32){IN[31]}}, IN};
                    r_stg <= 2'd1;
                end
                if (r_stg == 2'd1) begin
                    r_c1  <= w_c1;
                    r_stg <= 2'd2;
                end
                if (r_stg == 2'd2) begin
                    r_c2      <= w_c2;
                    r_ptr     <= r_ptr + 1'b1;
                    r_pending <= 1'b1;
                    r_stg     <= 2'd0;
                end
                if (w_take) begin
                    r_pending <= 1'b0;
                end
                if (w_tick) begin
                    r_int1  <= w_int1_n;
                    r_int2  <= w_int2_n;
                    r_out   <= w_out_sat;
                    r_phase <= w_phase_next;
                end
            end
        end
    end

    cic_delay_line #(
        .W    (CW),
        .DEPTH(CIC_DLY_DEPTH),
        .AW   (AW)
    ) u_line1 (
        .clk    (clk),
        .i_we   (w_we1),
        .i_waddr(w_waddr),
        .i_wdata(w_wdata1),
        .i_raddr(w_raddr),
        .o_rdata(w_d1)
    );

    cic_delay_line #(
        .W    (CW),
        .DEPTH(CIC_DLY_DEPTH),
        .AW   (AW)
    ) u_line2 (
        .clk    (clk),
        .i_we   (w_we2),
        .i_waddr(w_waddr),
        .i_wdata(w_wdata2),
        .i_raddr(w_raddr),
        .o_rdata(w_d2)
    );

endmodule

// File: tb/tb_cic_interp.sv
// Bench for cic_interp: behavioural CIC model checked every cycle, plus directed
// literal expectations for clear timing, step responses, underrun and reset.
module tb_cic_interp;

    localparam int unsigned RATE     = 2;
    localparam int unsigned LOG2RATE = 1;
    localparam longint S32_MAX = 64'sd2147483647;
    localparam longint S32_MIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hi_tick = 1'b0;
    logic [3:0]  TC = 4'd0;
    logic [31:0] IN = 32'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] OUT;
    logic        out_tick;
    logic        busy;
    logic        underrun;
    logic        underrun_clr = 1'b0;

    cic_interp #(
        .RATE    (RATE),
        .LOG2RATE(LOG2RATE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hi_tick     (hi_tick),
        .TC          (TC),
        .IN          (IN),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .OUT         (OUT),
        .out_tick    (out_tick),
        .busy        (busy),
        .underrun    (underrun),
        .underrun_clr(underrun_clr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: direct comb formula over the low-rate input history,
    // zero-stuffed double integration, shift and saturation.
    int     clr_left = 256;
    int     tc_m = 0;
    int     phase_m = 0;
    longint int1_m = 0, int2_m = 0, out_m = 0;
    bit     tick_m = 1'b0, und_m = 1'b0, und_new;
    longint hist[$];
    longint combq[$];
    int     tcc, mm, nn;
    longint inj;

    function automatic longint hx(input int k);
        return (k < 0) ? 64'sd0 : hist[k];
    endfunction

    function automatic longint sat32(input longint v);
        if (v > S32_MAX) return S32_MAX;
        if (v < S32_MIN) return S32_MIN;
        return v;
    endfunction

    always @(negedge clk) begin : monitor
        if (!rst_n) begin
            clr_left = 256; tc_m = 0; phase_m = 0;
            int1_m = 0; int2_m = 0; out_m = 0; tick_m = 0; und_m = 0;
            hist.delete(); combq.delete();
        end
        chk("busy", busy, (clr_left > 0) ? 1 : 0);
        chk("OUT", longint'($signed(OUT)), out_m);
        chk("out_tick", out_tick, tick_m);
        chk("underrun", underrun, und_m);
        if (clr_left > 0 || combq.size() != 0) chk("in_ready_low", in_ready, 0);
        if (rst_n) begin
            tick_m  = 0;
            und_new = 0;
            if (clr_left > 0) begin
                clr_left--;
            end else begin
                tcc = (TC > 4'd7) ? 7 : int'(TC);
                if (tcc != tc_m) begin
                    tc_m = tcc; int1_m = 0; int2_m = 0;
                    combq.delete(); hist.delete(); clr_left = 256;
                end else begin
                    if (in_valid && in_ready) begin
                        mm = 1 << tc_m;
                        nn = hist.size();
                        hist.push_back(longint'($signed(IN)));
                        combq.push_back(hx(nn) - 2 * hx(nn - mm) + hx(nn - 2 * mm));
                    end
                    if (hi_tick) begin
                        inj = 0;
                        if (phase_m == 0) begin
                            if (combq.size() > 0) inj = combq.pop_front();
                            else und_new = 1;
                        end
                        int1_m += inj;
                        int2_m += int1_m;
                        out_m   = sat32(int2_m >>> (2 * tc_m + LOG2RATE));
                        tick_m  = 1;
                        phase_m = (phase_m + 1) % RATE;
                    end
                end
            end
            und_m = (und_m && !underrun_clr) || und_new;
        end
    end

    longint got[$];
    int     n_otick = 0;

    always @(negedge clk) begin
        if (out_tick) begin
            got.push_back(longint'($signed(OUT)));
            n_otick++;
        end
    end

    task automatic tick(input bit clr = 1'b0);
        @(posedge clk); #1;
        hi_tick = 1'b1; underrun_clr = clr;
        @(posedge clk); #1;
        hi_tick = 1'b0; underrun_clr = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic send(input int x);
        int w;
        @(posedge clk); #1;
        IN = x; in_valid = 1'b1; w = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            w++;
            if (w > 100) begin
                n_chk++; n_fail++;
                $display("FAIL send_timeout: got in_ready=0 for %0d clk, expected 1", w);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic frame(input int x);
        send(x);
        repeat (RATE) tick();
    endtask

    task automatic wait_clear(output int cnt);
        cnt = 0;
        while (cnt < 600) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
        end
    endtask

    int cnt;
    bit mono, below;

    initial begin
        // Reset, then clear with hi_ticks that must be ignored
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        fork
            wait_clear(cnt);
            begin tick(); tick(); tick(); end
        join
        chk("clear_len_reset", cnt, 256);
        chk("no_out_tick_in_clear", n_otick, 0);
        chk("in_ready_after_clear", in_ready, 1);
        chk("out_zero_after_clear", longint'($signed(OUT)), 0);

        // TC=0 step of 1000
        got.delete();
        repeat (4) frame(1000);
        chk("tc0_count", got.size(), 8);
        if (got.size() >= 8) begin
            chk("tc0_out0", got[0], 500);
            chk("tc0_out1", got[1], 1000);
            chk("tc0_out2", got[2], 1000);
            chk("tc0_out7", got[7], 1000);
        end
        chk("tc0_no_underrun", underrun, 0);

        // TC=1 step of 800
        @(posedge clk); #1 TC = 4'd1;
        @(posedge clk);
        wait_clear(cnt);
        chk("clear_len_tc1", cnt, 256);
        got.delete();
        repeat (6) frame(800);
        chk("tc1_count", got.size(), 12);
        mono = 1; below = 1;
        for (int i = 0; i < got.size(); i++) begin
            if (got[i] > 800) below = 0;
            if (i > 0 && got[i] < got[i-1]) mono = 0;
        end
        chk("tc1_monotonic", mono, 1);
        chk("tc1_no_overshoot", below, 1);
        if (got.size() >= 12) begin
            chk("tc1_out0", got[0], 100);
            chk("tc1_out2", got[2], 400);
            chk("tc1_settled_frame3", got[5], 800);
            chk("tc1_final", got[11], 800);
        end

        // Withheld sample: underrun, no drift
        repeat (RATE) tick();
        chk("ur_set", underrun, 1);
        chk("ur_out_hold", longint'($signed(OUT)), 800);
        repeat (2) frame(800);
        chk("ur_no_drift", longint'($signed(OUT)), 800);
        @(posedge clk); #1 underrun_clr = 1'b1;
        @(posedge clk); #1 underrun_clr = 1'b0;
        @(negedge clk);
        chk("ur_cleared", underrun, 0);
        tick(1'b1);
        chk("ur_new_wins_clr", underrun, 1);
        tick();
        @(posedge clk); #1 underrun_clr = 1'b1;
        @(posedge clk); #1 underrun_clr = 1'b0;

        // TC change to 2: clear, hold OUT, then -500 step
        @(posedge clk); #1 TC = 4'd2;
        @(posedge clk);
        wait_clear(cnt);
        chk("clear_len_tc2", cnt, 256);
        chk("tc2_out_held", longint'($signed(OUT)), 800);
        got.delete();
        repeat (12) frame(-500);
        if (got.size() >= 24) begin
            chk("tc2_out0", got[0], -16);
            chk("tc2_final", got[23], -500);
        end
        chk("tc2_count", got.size(), 24);

        // Reset mid-frame with a sample pending
        send(123);
        @(posedge clk); #3;
        rst_n = 1'b0; TC = 4'd0;
        #1;
        chk("rst_out", longint'($signed(OUT)), 0);
        chk("rst_out_tick", out_tick, 0);
        chk("rst_busy", busy, 1);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_underrun", underrun, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_clear(cnt);
        chk("clear_len_rst2", cnt, 256);
        tick();
        chk("rst_pending_dropped", underrun, 1);
        chk("rst_out_after", longint'($signed(OUT)), 0);
        tick();

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
